// File: rtl/channel_string_reader.sv
// channel_string_reader: drains channel FIFO packets onto a valid/ready stream.
// Optional header check compiled in with CHANNEL_READER_HEADER_CHECK_EN.
module channel_string_reader #(
    parameter int G_CHANNEL_ID   = 15,
    parameter int G_PACKET_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_Enable,
    input  logic        i_FifoEmpty,
    output logic        o_FifoRead,
    input  logic [15:0] i_FifoData,
    output logic [15:0] o_TxData,
    output logic        o_TxValid,
    input  logic        i_TxReady,
    output logic        o_TxLast,
    output logic [15:0] o_PacketCount,
    output logic        o_HeaderError
);

    localparam int IW = (G_PACKET_WORDS > 1) ? $clog2(G_PACKET_WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(G_PACKET_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic          pend;
    logic          pend_last;
    logic [15:0]   d0;
    logic [15:0]   d1;
    logic          l0;
    logic          l1;
    logic [1:0]    cnt;
    logic [1:0]    occ;
    logic          pop;
    logic          push;
    logic          rd_ok;
    logic          boundary;

    assign o_TxValid = (cnt != 2'd0);
    assign o_TxData  = d0;
    assign o_TxLast  = l0 & o_TxValid;
    assign pop       = o_TxValid & i_TxReady;
    assign push      = pend;
    assign occ       = cnt + {1'b0, pend};
    assign boundary  = (idx == '0) && !pend;

    // Run state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: disable only takes effect once the packet is fully read
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (i_Enable) state_nxt = RUN;
            RUN:     if (!i_Enable) state_nxt = boundary ? IDLE : DRAIN;
            DRAIN:   if (boundary) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read strobe: no new header is fetched once enable is gone
    always_comb begin
        rd_ok = 1'b0;
        unique case (state)
            RUN:     rd_ok = i_Enable || (idx != '0);
            DRAIN:   rd_ok = (idx != '0);
            default: rd_ok = 1'b0;
        endcase
        o_FifoRead = !i_FifoEmpty && rd_ok && ((occ < 2'd2) || pop);
    end

    // Word index and in-flight read tracking, tag taken at issue time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            pend <= o_FifoRead;
            if (o_FifoRead) begin
                pend_last <= (idx == LAST_IDX);
                idx       <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Two-entry output buffer, head in d0/l0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0  <= '0;
            d1  <= '0;
            l0  <= 1'b0;
            l1  <= 1'b0;
            cnt <= 2'd0;
        end else if (push && pop) begin
            if (cnt == 2'd2) begin
                d0 <= d1;
                l0 <= l1;
                d1 <= i_FifoData;
                l1 <= pend_last;
            end else begin
                d0 <= i_FifoData;
                l0 <= pend_last;
            end
        end else if (pop) begin
            d0  <= d1;
            l0  <= l1;
            cnt <= cnt - 2'd1;
        end else if (push) begin
            if (cnt == 2'd0) begin
                d0 <= i_FifoData;
                l0 <= pend_last;
            end else begin
                d1 <= i_FifoData;
                l1 <= pend_last;
            end
            cnt <= cnt + 2'd1;
        end
    end

    // Completed packet counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                o_PacketCount <= '0;
        else if (pop && o_TxLast) o_PacketCount <= o_PacketCount + 16'd1;
    end

`ifdef CHANNEL_READER_HEADER_CHECK_EN
    localparam logic [7:0] CHAN = 8'(G_CHANNEL_ID);
    logic pend_hdr;

    // Sticky flag for headers carrying a foreign channel address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hdr      <= 1'b0;
            o_HeaderError <= 1'b0;
        end else begin
            if (o_FifoRead) pend_hdr <= (idx == '0);
            if (push && pend_hdr && (i_FifoData[7:0] != CHAN))
                o_HeaderError <= 1'b1;
        end
    end
`else
    assign o_HeaderError = 1'b0;
`endif

endmodule

// File: tb/tb_channel_string_reader.sv
// Directed bench for channel_string_reader with a behavioural FIFO model.
// A second instance with 1-word packets exercises the packet counter wrap.
module tb_channel_string_reader;

`ifdef CHANNEL_READER_HEADER_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        ready;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [15:0] fifo_data = '0;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic [15:0] pkt_cnt;
    logic        hdr_err;

    logic        w_en;
    logic        w_rd;
    logic [15:0] w_data = 16'h000F;
    logic [15:0] w_tx;
    logic        w_valid;
    logic        w_last;
    logic [15:0] w_cnt;
    logic        w_err;

    logic [15:0] mem [0:255];
    int          wp = 0;
    int          rp = 0;
    logic        flush = 1'b0;

    logic [15:0] exp_q [$];
    logic        exp_l [$];
    int          acc_total = 0;
    int          max_occ = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    channel_string_reader u_dut (
        .clk           (clk),
        .reset         (reset),
        .i_Enable      (enable),
        .i_FifoEmpty   (fifo_empty),
        .o_FifoRead    (fifo_rd),
        .i_FifoData    (fifo_data),
        .o_TxData      (tx_data),
        .o_TxValid     (tx_valid),
        .i_TxReady     (ready),
        .o_TxLast      (tx_last),
        .o_PacketCount (pkt_cnt),
        .o_HeaderError (hdr_err)
    );

    channel_string_reader #(.G_PACKET_WORDS(1)) u_wrap (
        .clk           (clk),
        .reset         (reset),
        .i_Enable      (w_en),
        .i_FifoEmpty   (1'b0),
        .o_FifoRead    (w_rd),
        .i_FifoData    (w_data),
        .o_TxData      (w_tx),
        .o_TxValid     (w_valid),
        .i_TxReady     (1'b1),
        .o_TxLast      (w_last),
        .o_PacketCount (w_cnt),
        .o_HeaderError (w_err)
    );

    assign fifo_empty = (wp == rp);

    // channel FIFO model, one cycle read latency
    always @(posedge clk) begin
        if (flush) rp <= wp;
        else if (fifo_rd) begin
            fifo_data <= mem[rp % 256];
            rp        <= rp + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_pkt(input logic [15:0] hdr, input logic [15:0] base);
        mem[wp % 256] = hdr;
        wp++;
        exp_q.push_back(hdr);
        exp_l.push_back(1'b0);
        for (int i = 1; i < 16; i++) begin
            mem[wp % 256] = base + 16'(i);
            wp++;
            exp_q.push_back(base + 16'(i));
            exp_l.push_back(i == 15);
        end
    endtask

    // mode 0: ready held high, mode 1: ready pattern 1,0,0,1
    task automatic drain(input int n, input int mode,
                         output int first, output int span);
        int got_n = 0;
        int cyc = 0;
        int lastc = 0;
        int occ;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [15:0] pd = '0;
        logic pl = 1'b0;
        first = -1;
        while (got_n < n && cyc < 400) begin
            @(negedge clk);
            ready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            if (pv && !pr) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, pd);
                check("hold_last", tx_last, pl);
            end
            occ = rp - acc_total;
            if (occ > max_occ) max_occ = occ;
            if (tx_valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", exp_q.size(), 1);
                end else begin
                    check("data", tx_data, exp_q.pop_front());
                    check("last", tx_last, exp_l.pop_front());
                end
                if (first < 0) first = cyc;
                lastc = cyc;
                got_n++;
                acc_total++;
            end
            pv = tx_valid;
            pr = ready;
            pd = tx_data;
            pl = tx_last;
            cyc++;
        end
        if (got_n < n) check("drain_timeout", got_n, n);
        span = lastc - first;
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int span;
        int rp0;
        int rd_seen;
        int v_seen;
        int cyc;
        reset  = 1'b1;
        enable = 1'b0;
        ready  = 1'b0;
        w_en   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", tx_valid, 0);
        check("rst_read", fifo_rd, 0);
        check("rst_count", pkt_cnt, 0);
        check("rst_err", hdr_err, 0);
        check("rst_last", tx_last, 0);
        check("rst_data", tx_data, 0);

        // single packet with latency checks
        push_pkt(16'h000F, 16'h0100);
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_read", fifo_rd, 0);
        enable = 1'b1;
        ready  = 1'b1;
        @(negedge clk);
        check("read_after_en", fifo_rd, 1);
        check("lat_valid0", tx_valid, 0);
        @(negedge clk);
        check("lat_valid1", tx_valid, 0);
        drain(16, 0, first, span);
        check("first_valid", first, 0);
        check("single_span", span, 15);
        @(negedge clk);
        ready = 1'b0;
        check("single_count", pkt_cnt, 1);
        check("single_err", hdr_err, 0);
        check("single_empty", tx_valid, 0);

        // backpressure
        push_pkt(16'h000F, 16'h0100);
        max_occ = 0;
        drain(16, 1, first, span);
        @(negedge clk);
        ready = 1'b0;
        check("bp_count", pkt_cnt, 2);
        check("bp_max_occ", max_occ, 2);

        // pileup
        push_pkt(16'h000F, 16'h0200);
        push_pkt(16'h000F, 16'h0300);
        drain(32, 0, first, span);
        check("pile_span", span, 31);
        @(negedge clk);
        ready = 1'b0;
        check("pile_count", pkt_cnt, 4);

        // bad header followed by a good one
        push_pkt(16'h0003, 16'h0400);
        push_pkt(16'h000F, 16'h0500);
        drain(16, 0, first, span);
        @(negedge clk);
        ready = 1'b0;
        check("bad_err", hdr_err, EXP_ERR);
        check("bad_count", pkt_cnt, 5);
        drain(16, 0, first, span);
        @(negedge clk);
        ready = 1'b0;
        check("bad_err_sticky", hdr_err, EXP_ERR);
        check("bad_count2", pkt_cnt, 6);

        // disable mid-packet
        rp0 = rp;
        push_pkt(16'h000F, 16'h0600);
        push_pkt(16'h000F, 16'h0700);
        drain(5, 0, first, span);
        enable = 1'b0;
        drain(11, 0, first, span);
        rd_seen = 0;
        v_seen  = 0;
        repeat (10) begin
            @(negedge clk);
            rd_seen += int'(fifo_rd);
            v_seen  += int'(tx_valid);
        end
        check("dis_no_read", rd_seen, 0);
        check("dis_no_word", v_seen, 0);
        check("dis_reads", rp - rp0, 16);
        check("dis_count", pkt_cnt, 7);
        enable = 1'b1;
        drain(16, 0, first, span);
        @(negedge clk);
        ready = 1'b0;
        check("reen_count", pkt_cnt, 8);

        // reset mid-packet
        push_pkt(16'h000F, 16'h0800);
        drain(8, 0, first, span);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_read", fifo_rd, 0);
        check("mid_rst_count", pkt_cnt, 0);
        check("mid_rst_data", tx_data, 0);
        check("mid_rst_last", tx_last, 0);
        check("mid_rst_err", hdr_err, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("rst_hold_read", fifo_rd, 0);
        exp_q.delete();
        exp_l.delete();
        reset = 1'b0;
        push_pkt(16'h000F, 16'h0900);
        drain(16, 0, first, span);
        @(negedge clk);
        ready = 1'b0;
        check("post_rst_count", pkt_cnt, 1);
        check("post_rst_err", hdr_err, 0);

        // packet counter wrap with 1-word packets
        w_en = 1'b1;
        cyc  = 0;
        while (w_cnt != 16'hFFFF && cyc < 70000) begin
            @(negedge clk);
            cyc++;
        end
        check("wrap_reach", w_cnt, 16'hFFFF);
        check("wrap_last", w_last, 1);
        @(negedge clk);
        check("wrap_zero", w_cnt, 16'h0000);
        check("wrap_err", w_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
